div_ctrl: RTL and testbench

Multi-cycle divide sequencer serving the EX stage for DIV/DIVU. It accepts a division request from EX and holds the pipeline through the stall bus while it runs a 32-iteration restoring divide. It then presents the 64-bit {remainder, quotient} result that EX forwards down the pipe as the HI/LO write carried on the hilo_op path to WB. A flush annuls it.

---
 rtl/div_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_div_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/div_ctrl.sv
// 32-cycle restoring divide sequencer for DIV/DIVU in the EX stage; result_o = {remainder, quotient}.
// Define DIV_SIGNED_EN to honour signed_i; without it every divide is unsigned and no negation logic exists.
//
// state   | meaning
// IDLE    | waiting for start_i
// DIVZERO | divisor was zero, result forced to 0
// ON      | one restoring iteration per cycle, cnt 0..31
// END     | result presented until start_i drops
module div_ctrl (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start_i,
    input  logic        signed_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    input  logic        annul_i,
    output logic        stallreq_o,
    output logic        ready_o,
    output logic [63:0] result_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DIVZERO = 2'd1,
        ST_ON      = 2'd2,
        ST_END     = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [64:0] work_q, work_d;
    logic [31:0] dvs_q, dvs_d;
    logic        ready_q, ready_d;
    logic [63:0] result_q, result_d;

    logic [31:0] dvd_mag;
    logic [31:0] dvs_mag;
    logic [64:0] shifted;
    logic [64:0] step;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

`ifdef DIV_SIGNED_EN
    logic quo_neg_q, quo_neg_d;
    logic rem_neg_q, rem_neg_d;
    logic dvd_neg;
    logic dvs_neg;
`else
    logic unused_signed;
    assign unused_signed = signed_i;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 5'd0;
            work_q    <= 65'd0;
            dvs_q     <= 32'd0;
            ready_q   <= 1'b0;
            result_q  <= 64'd0;
`ifdef DIV_SIGNED_EN
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            dvs_q     <= dvs_d;
            ready_q   <= ready_d;
            result_q  <= result_d;
`ifdef DIV_SIGNED_EN
            quo_neg_q <= quo_neg_d;
            rem_neg_q <= rem_neg_d;
`endif
        end
    end

    // Operand magnitudes at capture; in the unsigned build these are the raw buses.
    always_comb begin
`ifdef DIV_SIGNED_EN
        dvd_neg = signed_i & dividend_i[31];
        dvs_neg = signed_i & divisor_i[31];
        dvd_mag = dvd_neg ? (~dividend_i + 32'd1) : dividend_i;
        dvs_mag = dvs_neg ? (~divisor_i + 32'd1) : divisor_i;
`else
        dvd_mag = dividend_i;
        dvs_mag = divisor_i;
`endif
    end

    // One restoring step; the partial remainder stays below the divisor so work_q[64] is always 0.
    always_comb begin
        shifted = {work_q[63:0], 1'b0};
        step    = shifted;
        if (shifted[64:32] >= {1'b0, dvs_q}) begin
            step = {shifted[64:32] - {1'b0, dvs_q}, shifted[31:1], 1'b1};
        end
    end

    always_comb begin
`ifdef DIV_SIGNED_EN
        quo_fix = quo_neg_q ? (~step[31:0] + 32'd1) : step[31:0];
        rem_fix = rem_neg_q ? (~step[63:32] + 32'd1) : step[63:32];
`else
        quo_fix = step[31:0];
        rem_fix = step[63:32];
`endif
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        dvs_d     = dvs_q;
        ready_d   = ready_q;
        result_d  = result_q;
`ifdef DIV_SIGNED_EN
        quo_neg_d = quo_neg_q;
        rem_neg_d = rem_neg_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (divisor_i == 32'd0) begin
                        state_d = ST_DIVZERO;
                    end else begin
                        state_d   = ST_ON;
                        work_d    = {33'd0, dvd_mag};
                        dvs_d     = dvs_mag;
                        cnt_d     = 5'd0;
`ifdef DIV_SIGNED_EN
                        quo_neg_d = dvd_neg ^ dvs_neg;
                        rem_neg_d = dvd_neg;
`endif
                    end
                end
            end
            ST_DIVZERO: begin
                state_d  = ST_END;
                result_d = 64'd0;
                ready_d  = 1'b1;
            end
            ST_ON: begin
                work_d = step;
                cnt_d  = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d  = ST_END;
                    result_d = {rem_fix, quo_fix};
                    ready_d  = 1'b1;
                end
            end
            ST_END: begin
                if (!start_i) begin
                    state_d = ST_IDLE;
                    ready_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b0;
            end
        endcase

        // Flush wins over every transition but leaves the last result on result_o.
        if (annul_i) begin
            state_d  = ST_IDLE;
            ready_d  = 1'b0;
            cnt_d    = 5'd0;
            result_d = result_q;
        end
    end

    assign stallreq_o = ((state_q == ST_IDLE) & start_i & ~annul_i)
                      | (state_q == ST_DIVZERO)
                      | (state_q == ST_ON);
    assign ready_o    = ready_q;
    assign result_o   = result_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl: latency, stall window, results, flush and async reset behaviour.
// Expected values for signed requests follow DIV_SIGNED_EN (unsigned results when it is undefined).
module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start_i = 1'b0;
    logic        signed_i = 1'b0;
    logic [31:0] dividend_i = 32'd0;
    logic [31:0] divisor_i = 32'd0;
    logic        annul_i = 1'b0;
    logic        stallreq_o;
    logic        ready_o;
    logic [63:0] result_o;

    int err_cnt = 0;
    int chk_cnt = 0;

    div_ctrl u_dut (
        .clk        (clk),
        .resetn     (resetn),
        .start_i    (start_i),
        .signed_i   (signed_i),
        .dividend_i (dividend_i),
        .divisor_i  (divisor_i),
        .annul_i    (annul_i),
        .stallreq_o (stallreq_o),
        .ready_o    (ready_o),
        .result_o   (result_o)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Starts a divide, scrambles the operand buses while it runs, and leaves start_i high at ready.
    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic sg, input logic [63:0] exp_res, input int exp_lat);
        int lat;
        bit stall_ok;
        @(posedge clk); #1;
        start_i    = 1'b1;
        signed_i   = sg;
        dividend_i = a;
        divisor_i  = b;
        @(negedge clk);
        check_val({tag, "_stall_c0"}, 64'(stallreq_o), 64'd1);
        lat = 0;
        stall_ok = 1'b1;
        while (ready_o !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            dividend_i = ~dividend_i;
            divisor_i  = divisor_i ^ 32'h5A5A_0001;
            signed_i   = ~signed_i;
            @(negedge clk);
            lat++;
            if (ready_o !== 1'b1 && stallreq_o !== 1'b1) stall_ok = 1'b0;
        end
        check_val({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check_val({tag, "_stall_window"}, 64'(stall_ok), 64'd1);
        check_val({tag, "_stall_at_ready"}, 64'(stallreq_o), 64'd0);
        check_val({tag, "_result"}, result_o, exp_res);
    endtask

    task automatic release_div(input string tag);
        @(posedge clk); #1;
        start_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_val({tag, "_ready_cleared"}, 64'(ready_o), 64'd0);
        check_val({tag, "_stall_idle"}, 64'(stallreq_o), 64'd0);
    endtask

    logic [63:0] exp_neg7;
    logic [63:0] exp_min;
    logic [63:0] exp_20;
    bit          ready_seen;

    initial begin
`ifdef DIV_SIGNED_EN
        exp_neg7 = {32'hFFFF_FFFF, 32'hFFFF_FFFD};
        exp_min  = {32'h0000_0000, 32'h8000_0000};
        exp_20   = {32'h0000_0002, 32'hFFFF_FFFA};
`else
        exp_neg7 = {32'h0000_0001, 32'h7FFF_FFFC};
        exp_min  = {32'h8000_0000, 32'h0000_0000};
        exp_20   = {32'h0000_0014, 32'h0000_0000};
`endif

        repeat (2) @(negedge clk);
        check_val("rst_stall", 64'(stallreq_o), 64'd0);
        check_val("rst_ready", 64'(ready_o), 64'd0);
        check_val("rst_result", result_o, 64'd0);
        resetn = 1'b1;

        // 7 / 2, then hold start_i through END
        run_div("u7d2", 32'd7, 32'd2, 1'b0, {32'h1, 32'h3}, 33);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("hold_ready", 64'(ready_o), 64'd1);
            check_val("hold_result", result_o, {32'h1, 32'h3});
        end
        release_div("u7d2");

        run_div("s_neg7d2", 32'hFFFF_FFF9, 32'h2, 1'b1, exp_neg7, 33);
        release_div("s_neg7d2");

        run_div("u_ffffd10", 32'hFFFF_FFFF, 32'h10, 1'b0, {32'hF, 32'h0FFF_FFFF}, 33);
        release_div("u_ffffd10");

        run_div("s_min", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, exp_min, 33);
        release_div("s_min");

        run_div("s_20dm3", 32'd20, 32'hFFFF_FFFD, 1'b1, exp_20, 33);
        release_div("s_20dm3");

        // flush in cycle 10 of an ON run
        @(posedge clk); #1;
        start_i = 1'b1; signed_i = 1'b0; dividend_i = 32'd1000; divisor_i = 32'd3;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
        end
        annul_i = 1'b1;
        @(negedge clk);
        check_val("annul_c10_stall", 64'(stallreq_o), 64'd1);
        @(posedge clk); #1;
        annul_i = 1'b0;
        start_i = 1'b0;
        @(negedge clk);
        check_val("annul_c11_stall", 64'(stallreq_o), 64'd0);
        check_val("annul_c11_ready", 64'(ready_o), 64'd0);
        check_val("annul_keeps_result", result_o, exp_20);
        ready_seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (ready_o === 1'b1) ready_seen = 1'b1;
        end
        check_val("annul_no_ready", 64'(ready_seen), 64'd0);

        run_div("after_annul", 32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 33);
        release_div("after_annul");

        // flush beats a start in IDLE
        @(posedge clk); #1;
        start_i = 1'b1; annul_i = 1'b1; dividend_i = 32'd50; divisor_i = 32'd5;
        @(negedge clk);
        check_val("idle_annul_stall", 64'(stallreq_o), 64'd0);
        @(posedge clk); #1;
        start_i = 1'b0; annul_i = 1'b0;
        @(negedge clk);
        check_val("idle_annul_stall_next", 64'(stallreq_o), 64'd0);
        check_val("idle_annul_ready", 64'(ready_o), 64'd0);

        run_div("divzero", 32'h1234, 32'h0, 1'b0, 64'd0, 2);
        release_div("divzero");

        // flush coincident with ready
        run_div("u9d4", 32'd9, 32'd4, 1'b0, {32'd1, 32'd2}, 33);
        @(posedge clk); #1;
        annul_i = 1'b1;
        @(negedge clk);
        check_val("ready_annul_same_cycle", 64'(ready_o), 64'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check_val("ready_annul_ready", 64'(ready_o), 64'd0);
        check_val("ready_annul_stall", 64'(stallreq_o), 64'd0);
        check_val("ready_annul_result", result_o, {32'd1, 32'd2});
        @(posedge clk); #1;
        annul_i = 1'b0; start_i = 1'b0;

        // async reset in cycle 20 of a run
        @(posedge clk); #1;
        start_i = 1'b1; signed_i = 1'b0; dividend_i = 32'd77; divisor_i = 32'd5;
        repeat (20) @(posedge clk);
        #1;
        start_i = 1'b0;
        resetn  = 1'b0;
        #1;
        check_val("midrst_stall", 64'(stallreq_o), 64'd0);
        check_val("midrst_ready", 64'(ready_o), 64'd0);
        check_val("midrst_result", result_o, 64'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        ready_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ready_o === 1'b1 || stallreq_o === 1'b1) ready_seen = 1'b1;
        end
        check_val("midrst_quiet", 64'(ready_seen), 64'd0);

        run_div("after_rst", 32'h1234_5678, 32'h1000, 1'b0, {32'h678, 32'h12345}, 33);
        release_div("after_rst");

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
